rp_mask_gen: RTL and testbench
==============================

RP_MASK_GEN -- requirements
Module: rp_mask_gen

Interface
REQ-001 SHALL have parameter SENSOR_W, default 300, mask row width in pixels.
REQ-002 SHALL have parameter SENSOR_H, default 300, rows per frame (1..2047).
REQ-003 SHALL have parameter PAT_W_MAX, default 8, max pattern width.
REQ-004 SHALL have parameter PAT_H_MAX, default 8, max pattern height.
REQ-005 SHALL have ports:
 clk  in  1  clock, rising edge;
 rst_n  in  1  reset, asynchronous, active-low;
 clk_en  in  1  global enable, all state advances only when high;
 start  in  1  frame request pulse;
 abort  in  1  cancel current frame;
 pattern_w  in  4  pattern width, legal 1..PAT_W_MAX;
 pattern_h  in  4  pattern height, legal 1..PAT_H_MAX;
 pattern  in  PAT_W_MAX*PAT_H_MAX  pattern bits, bit (r*PAT_W_MAX+c) = row r, column c;
 shift  in  4  per-row horizontal phase advance (diagonal mode), 0 = plain tiling;
 invert  in  1  invert every output bit;
 mask_row  out  SENSOR_W  current mask row, bit 0 = column 0;
 mask_valid  out  1  mask_row valid;
 mask_ready  in  1  downstream accepts row;
 row_idx  out  11  index of row on mask_row;
 busy  out  1  frame in progress;
 frame_done  out  1  one-cycle pulse after last row accepted;
 cfg_err  out  1  one-cycle pulse on illegal start.

Function
REQ-006 SHALL implement states IDLE, GEN, PRESENT, DONE.
REQ-007 In IDLE, start=1 with legal config SHALL latch pattern_w, pattern_h, pattern, shift, invert and go to GEN; config inputs are ignored until the next IDLE.
REQ-008 Start with pattern_w or pattern_h equal to 0 or above its max SHALL pulse cfg_err for one cycle and stay in IDLE.
REQ-009 Start outside IDLE SHALL be ignored.
REQ-010 Row r, column c SHALL equal pattern[(r mod h)*PAT_W_MAX + ((c + r*shift) mod w)] XOR invert, using latched h, w, shift.
REQ-011 Tracking SHALL use two wrap counters, no multiply or divide:
 - pattern-row counter, 0..h-1;
 - phase counter, advanced by (shift mod w) mod w per row.
REQ-012 GEN SHALL compute one full row in one cycle, then go to PRESENT.
REQ-013 In PRESENT, mask_valid=1; mask_row and row_idx SHALL hold stable while mask_ready=0.
REQ-014 Handshake completes on an enabled edge with mask_valid=1 and mask_ready=1.
 - row_idx < SENSOR_H-1: SHALL advance the counters and go to GEN.
 - Last row: SHALL go to DONE.
REQ-015 Latency: mask_valid SHALL rise on the 2nd enabled edge after start is sampled; back-to-back rows with mask_ready held high SHALL occur every 2 enabled cycles.
REQ-016 DONE SHALL assert frame_done for exactly one cycle and return to IDLE.
REQ-017 busy SHALL be 1 in GEN, PRESENT and DONE.
REQ-018 abort=1 on an enabled edge in any state SHALL return to IDLE, clear mask_valid and emit no frame_done; abort SHALL win over a simultaneous start or handshake.
REQ-019 clk_en=0 SHALL freeze all registers and outputs; start, abort and mask_ready SHALL be ignored that cycle.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 rst_n=0 SHALL asynchronously force state IDLE and clear all counters and latched config.
 - Outputs: mask_row=0, mask_valid=0, row_idx=0, busy=0, frame_done=0, cfg_err=0.
REQ-022 Reset mid-frame SHALL discard the frame; after release the block SHALL wait for a new start.

Verification
REQ-023 w=2, h=2, pattern rows 10/01, shift=0, SENSOR_W=8, mask_ready=1 -> rows alternate 0x55/0xAA; frame_done pulses once after row SENSOR_H-1.
REQ-024 w=3, h=1, pattern=100, shift=1 -> row0 col0=1 every 3rd column, and each row's ones shift by one column per row; invert=1 gives the bitwise complement.
REQ-025 Stall: mask_ready=0 for 5 cycles on row 4 -> mask_row/row_idx=4 held stable, no row skipped or duplicated.
REQ-026 start with pattern_w=0 -> cfg_err one-cycle pulse, busy stays 0; start with pattern_h=9 (PAT_H_MAX=8) -> same.
REQ-027 abort on row 10 coincident with handshake -> IDLE next edge, mask_valid=0, no frame_done; a new start restarts at row_idx=0.
REQ-028 clk_en toggled 1-0-1 with rst_n pulsed low mid-frame -> outputs frozen while clk_en=0; reset values appear immediately on rst_n=0.

Source files
------------

// File: rtl/rp_mask_gen.sv
`timescale 1ns/1ps
// Structured-light mask row generator: tiles a latched w x h bit pattern across a row,
// with an optional per-row diagonal phase shift, and hands rows out over a valid/ready link.
module rp_mask_gen #(
    parameter int SENSOR_W  = 300,
    parameter int SENSOR_H  = 300,
    parameter int PAT_W_MAX = 8,
    parameter int PAT_H_MAX = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clk_en,
    input  logic                             start,
    input  logic                             abort,
    input  logic [3:0]                       pattern_w,
    input  logic [3:0]                       pattern_h,
    input  logic [PAT_W_MAX*PAT_H_MAX-1:0]   pattern,
    input  logic [3:0]                       shift,
    input  logic                             invert,
    output logic [SENSOR_W-1:0]              mask_row,
    output logic                             mask_valid,
    input  logic                             mask_ready,
    output logic [10:0]                      row_idx,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             cfg_err
);

    typedef enum logic [1:0] {IDLE, GEN, PRESENT, DONE} state_t;

    localparam logic [3:0]  W_MAX    = 4'(PAT_W_MAX);
    localparam logic [3:0]  H_MAX    = 4'(PAT_H_MAX);
    localparam logic [10:0] LAST_ROW = 11'(SENSOR_H - 1);

    // Reduce a 4-bit value modulo m (m >= 1) by bounded repeated subtraction.
    function automatic logic [3:0] wrap_mod(input logic [3:0] v, input logic [3:0] m);
        logic [3:0] r;
        r = v;
        for (int i = 0; i < 15; i++) begin
            if (r >= m) r = r - m;
        end
        return r;
    endfunction

    state_t state_q, state_d;

    logic [3:0]                     w_q, h_q, sh_q, prow_q, phase_q;
    logic [PAT_W_MAX*PAT_H_MAX-1:0] pat_q;
    logic                           inv_q;

    logic                           cfg_ok, accept, advance;
    logic [4:0]                     phase_sum;
    logic [3:0]                     phase_next;
    logic [PAT_W_MAX-1:0]           pat_row, rot_row, sh_bits;
    logic [4:0]                     rot_idx;
    logic [SENSOR_W-1:0]            gen_row;

    logic [SENSOR_W-1:0]            mask_row_d;
    logic [10:0]                    row_idx_d;
    logic                           mask_valid_d, busy_d, frame_done_d, cfg_err_d;

    assign cfg_ok  = (pattern_w != 4'd0) && (pattern_w <= W_MAX) &&
                     (pattern_h != 4'd0) && (pattern_h <= H_MAX);
    assign accept  = !abort && (state_q == IDLE) && start && cfg_ok;
    assign advance = !abort && (state_q == PRESENT) && mask_ready && (row_idx != LAST_ROW);

    always_comb begin
        phase_sum = {1'b0, phase_q} + {1'b0, sh_q};
        if (phase_sum >= {1'b0, w_q}) phase_sum = phase_sum - {1'b0, w_q};
        phase_next = phase_sum[3:0];
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      state_q <= IDLE;
        else if (clk_en) state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start && cfg_ok) state_d = GEN;
                GEN:     state_d = PRESENT;
                PRESENT: if (mask_ready) state_d = (row_idx == LAST_ROW) ? DONE : GEN;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Latched frame config and the two wrap counters (pattern row, horizontal phase).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q     <= '0;
            h_q     <= '0;
            sh_q    <= '0;
            pat_q   <= '0;
            inv_q   <= 1'b0;
            prow_q  <= '0;
            phase_q <= '0;
        end else if (clk_en) begin
            if (accept) begin
                w_q     <= pattern_w;
                h_q     <= pattern_h;
                sh_q    <= wrap_mod(shift, pattern_w);
                pat_q   <= pattern;
                inv_q   <= invert;
                prow_q  <= '0;
                phase_q <= '0;
            end else if (advance) begin
                prow_q  <= (prow_q == h_q - 4'd1) ? 4'd0 : prow_q + 4'd1;
                phase_q <= phase_next;
            end
        end
    end

    // ---------------- Row generation ----------------
    always_comb begin
        pat_row = '0;
        for (int r = 0; r < PAT_H_MAX; r++) begin
            if (prow_q == 4'(r)) pat_row = pat_q[r*PAT_W_MAX +: PAT_W_MAX];
        end
    end

    // rot_row[j] = pattern column (j + phase) mod w; only j < w is ever consumed.
    always_comb begin
        rot_row = '0;
        rot_idx = '0;
        sh_bits = '0;
        for (int j = 0; j < PAT_W_MAX; j++) begin
            rot_idx = 5'(j) + {1'b0, phase_q};
            if (rot_idx >= {1'b0, w_q}) rot_idx = rot_idx - {1'b0, w_q};
            sh_bits    = pat_row >> rot_idx;
            rot_row[j] = sh_bits[0];
        end
    end

    // Column c takes rot_row[c mod w]; every legal w gets its own constant-folded tiling.
    always_comb begin
        gen_row = '0;
        for (int c = 0; c < SENSOR_W; c++) begin
            for (int wv = 1; wv <= PAT_W_MAX; wv++) begin
                if (w_q == 4'(wv)) gen_row[c] = rot_row[c % wv] ^ inv_q;
            end
        end
    end

    // ---------------- FSM: outputs (next values, registered below) ----------------
    always_comb begin
        mask_row_d   = mask_row;
        row_idx_d    = row_idx;
        mask_valid_d = (state_d == PRESENT);
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_d == DONE);
        cfg_err_d    = !abort && (state_q == IDLE) && start && !cfg_ok;
        if (accept)  row_idx_d = '0;
        if (advance) row_idx_d = row_idx + 11'd1;
        if (!abort && (state_q == GEN)) mask_row_d = gen_row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_row   <= '0;
            mask_valid <= 1'b0;
            row_idx    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else if (clk_en) begin
            mask_row   <= mask_row_d;
            mask_valid <= mask_valid_d;
            row_idx    <= row_idx_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            cfg_err    <= cfg_err_d;
        end
    end

endmodule

// File: tb/tb_rp_mask_gen.sv
`timescale 1ns/1ps
// Bench for rp_mask_gen: directed frames with literal rows plus randomized frames against a
// modulo-arithmetic row model; a negedge monitor checks every presented row and frame_done.
module tb_rp_mask_gen;

    localparam int SW  = 20;
    localparam int SH  = 12;
    localparam int PWM = 8;
    localparam int PHM = 8;

    logic          clk = 1'b0;
    logic          rst_n, clk_en, start, abort, invert, mask_ready;
    logic [3:0]    pattern_w, pattern_h, shift;
    logic [63:0]   pattern;
    logic [SW-1:0] mask_row;
    logic          mask_valid, busy, frame_done, cfg_err;
    logic [10:0]   row_idx;

    always #5 clk = ~clk;

    rp_mask_gen #(.SENSOR_W(SW), .SENSOR_H(SH), .PAT_W_MAX(PWM), .PAT_H_MAX(PHM)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start), .abort(abort),
        .pattern_w(pattern_w), .pattern_h(pattern_h), .pattern(pattern), .shift(shift),
        .invert(invert), .mask_row(mask_row), .mask_valid(mask_valid), .mask_ready(mask_ready),
        .row_idx(row_idx), .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the config of the frame in flight and the next row index expected.
    int          m_w = 1, m_h = 1, m_sh = 0;
    logic [63:0] m_pat = '0;
    bit          m_inv = 1'b0;
    int          exp_row = 0;
    bit          exp_fd = 1'b0;
    bit          ce_test = 1'b0;

    function automatic logic [SW-1:0] model_row(input int r);
        logic [SW-1:0] v;
        for (int c = 0; c < SW; c++)
            v[c] = m_pat[(r % m_h) * PWM + ((c + r * m_sh) % m_w)] ^ m_inv;
        return v;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_row = 0;
            exp_fd  = 1'b0;
        end else begin
            check("frame_done", {63'd0, frame_done}, {63'd0, exp_fd});
            if (!ce_test) check("cfg_err_idle", {63'd0, cfg_err}, 64'd0);
            if (mask_valid) begin
                check("row_idx", {53'd0, row_idx}, 64'(exp_row));
                check("mask_row", {44'd0, mask_row}, {44'd0, model_row(exp_row)});
            end
            if (clk_en) begin
                exp_fd = 1'b0;
                if (abort) exp_row = 0;
                else if (mask_valid && mask_ready) begin
                    if (exp_row == SH - 1) exp_fd = 1'b1;
                    else exp_row++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_start(input int w, input int h, input logic [63:0] p, input int sh, input bit inv);
        pattern_w = 4'(w); pattern_h = 4'(h); pattern = p; shift = 4'(sh); invert = inv;
        start = 1'b1; clk_en = 1'b1; abort = 1'b0;
        if (w >= 1 && w <= PWM && h >= 1 && h <= PHM) begin
            m_w = w; m_h = h; m_pat = p; m_sh = sh; m_inv = inv; exp_row = 0;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic idle_bound(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin tick(); n++; end
        check(name, {63'd0, busy}, 64'd0);
    endtask

    logic [SW-1:0] cap_row [0:40];
    logic [10:0]   cap_idx [0:40];
    bit            cap_v [0:40], cap_fd [0:40], cap_busy [0:40];

    task automatic capture(input int n);
        for (int k = 0; k <= n; k++) begin
            if (k > 0) tick();
            cap_row[k] = mask_row; cap_idx[k] = row_idx; cap_v[k] = mask_valid;
            cap_fd[k] = frame_done; cap_busy[k] = busy;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int nv, nfd, hs, stall, n;
        bit found;
        rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; abort = 1'b0; mask_ready = 1'b1;
        pattern_w = 4'd0; pattern_h = 4'd0; pattern = '0; shift = 4'd0; invert = 1'b0;
        tick(); tick();
        check("rst_mask_row", {44'd0, mask_row}, 64'd0);
        check("rst_mask_valid", {63'd0, mask_valid}, 64'd0);
        check("rst_row_idx", {53'd0, row_idx}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_frame_done", {63'd0, frame_done}, 64'd0);
        check("rst_cfg_err", {63'd0, cfg_err}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Checkerboard 10/01: alternating 0x55/0xAA rows, 2-cycle row cadence.
        issue_start(2, 2, 64'h0000_0000_0000_0201, 0, 1'b0);
        capture(26);
        check("lat_e0_valid", {63'd0, cap_v[0]}, 64'd0);
        check("lat_e1_valid", {63'd0, cap_v[1]}, 64'd1);
        check("b2b_gap_valid", {63'd0, cap_v[2]}, 64'd0);
        check("b2b_row1_valid", {63'd0, cap_v[3]}, 64'd1);
        check("b2b_row1_idx", {53'd0, cap_idx[3]}, 64'd1);
        check("chk_row0", {44'd0, cap_row[1]}, 64'h55555);
        check("chk_row1", {44'd0, cap_row[3]}, 64'hAAAAA);
        check("chk_row2", {44'd0, cap_row[5]}, 64'h55555);
        nv = 0; nfd = 0;
        for (int k = 0; k <= 26; k++) begin nv += int'(cap_v[k]); nfd += int'(cap_fd[k]); end
        check("chk_rows_presented", 64'(nv), 64'(SH));
        check("chk_fd_count", 64'(nfd), 64'd1);
        check("chk_fd_after_last", {63'd0, cap_fd[24]}, 64'd1);
        check("chk_busy_in_done", {63'd0, cap_busy[24]}, 64'd1);
        check("chk_busy_after", {63'd0, cap_busy[25]}, 64'd0);

        // Diagonal: w=3, h=1, pattern 100, shift 1, then inverted.
        issue_start(3, 1, 64'h1, 1, 1'b0);
        capture(26);
        check("diag_row0", {44'd0, cap_row[1]}, 64'h49249);
        check("diag_row1", {44'd0, cap_row[3]}, 64'h24924);
        check("diag_row2", {44'd0, cap_row[5]}, 64'h92492);
        issue_start(3, 1, 64'h1, 1, 1'b1);
        capture(26);
        check("diag_inv_row0", {44'd0, cap_row[1]}, 64'hB6DB6);
        check("diag_inv_row1", {44'd0, cap_row[3]}, 64'hDB6DB);

        // Stall row 4 for 5 cycles.
        issue_start(2, 3, 64'h0000_0000_0002_0301, 1, 1'b0);
        hs = 0; stall = 0;
        for (int i = 0; i < 150 && busy; i++) begin
            if (mask_valid && row_idx == 11'd4 && stall < 5) begin mask_ready = 1'b0; stall++; end
            else mask_ready = 1'b1;
            if (mask_valid && mask_ready) hs++;
            tick();
        end
        mask_ready = 1'b1;
        check("stall_timeout", {63'd0, busy}, 64'd0);
        check("stall_cycles_row4", 64'(stall), 64'd5);
        check("stall_handshakes", 64'(hs), 64'(SH));

        // Illegal configurations.
        ce_test = 1'b1;
        pattern_w = 4'd0; pattern_h = 4'd2; start = 1'b1;
        tick(); start = 1'b0;
        check("cfg_w0_err", {63'd0, cfg_err}, 64'd1);
        check("cfg_w0_busy", {63'd0, busy}, 64'd0);
        tick();
        check("cfg_w0_pulse_end", {63'd0, cfg_err}, 64'd0);
        check("cfg_w0_still_idle", {63'd0, busy}, 64'd0);
        pattern_w = 4'd2; pattern_h = 4'd9; start = 1'b1;
        tick(); start = 1'b0;
        check("cfg_h9_err", {63'd0, cfg_err}, 64'd1);
        check("cfg_h9_busy", {63'd0, busy}, 64'd0);
        tick();
        check("cfg_h9_pulse_end", {63'd0, cfg_err}, 64'd0);
        ce_test = 1'b0;

        // Abort coincident with the row-10 handshake.
        issue_start(4, 3, {$urandom, $urandom}, 3, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mask_valid && row_idx == 11'd10) found = 1'b1;
            else tick();
        end
        check("abort_reach_row10", {63'd0, found}, 64'd1);
        abort = 1'b1; mask_ready = 1'b1;
        tick(); abort = 1'b0;
        check("abort_valid", {63'd0, mask_valid}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        nfd = 0;
        for (int i = 0; i < 20; i++) begin nfd += int'(frame_done); tick(); end
        check("abort_no_fd", 64'(nfd), 64'd0);
        issue_start(5, 2, {$urandom, $urandom}, 2, 1'b1);
        tick();
        check("restart_valid", {63'd0, mask_valid}, 64'd1);
        check("restart_row_idx", {53'd0, row_idx}, 64'd0);
        idle_bound("restart_timeout", 200);

        // Freeze with clk_en=0, then asynchronous reset mid-frame.
        issue_start(2, 2, 64'h0000_0000_0000_0201, 0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (mask_valid && row_idx == 11'd2) found = 1'b1;
            else tick();
        end
        check("freeze_reach_row2", {63'd0, found}, 64'd1);
        clk_en = 1'b0; abort = 1'b1; start = 1'b1; mask_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("freeze_valid", {63'd0, mask_valid}, 64'd1);
            check("freeze_row_idx", {53'd0, row_idx}, 64'd2);
            check("freeze_mask_row", {44'd0, mask_row}, 64'h55555);
            check("freeze_busy", {63'd0, busy}, 64'd1);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_mask_row", {44'd0, mask_row}, 64'd0);
        check("arst_valid", {63'd0, mask_valid}, 64'd0);
        check("arst_row_idx", {53'd0, row_idx}, 64'd0);
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_frame_done", {63'd0, frame_done}, 64'd0);
        check("arst_cfg_err", {63'd0, cfg_err}, 64'd0);
        abort = 1'b0; start = 1'b0;
        tick();
        rst_n = 1'b1; clk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_idle_busy", {63'd0, busy}, 64'd0);
            check("post_rst_idle_valid", {63'd0, mask_valid}, 64'd0);
        end

        // Randomized frames with stalls, gaps, stray starts/config churn and rare aborts.
        for (int f = 0; f < 30; f++) begin
            issue_start($urandom_range(1, PWM), $urandom_range(1, PHM), {$urandom, $urandom},
                        $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            n = 0;
            while (busy && n < 600) begin
                clk_en     = ($urandom_range(0, 7) != 0);
                mask_ready = ($urandom_range(0, 3) != 0);
                abort      = ($urandom_range(0, 249) == 0);
                start      = ($urandom_range(0, 7) == 0);
                pattern_w  = 4'($urandom_range(0, 15));
                pattern_h  = 4'($urandom_range(0, 15));
                pattern    = {$urandom, $urandom};
                shift      = 4'($urandom_range(0, 15));
                invert     = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            start = 1'b0; abort = 1'b0; clk_en = 1'b1; mask_ready = 1'b1;
            check("rand_frame_timeout", {63'd0, busy}, 64'd0);
        end

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
